// File: rtl/box_rasterizer.sv
// box_rasterizer: accepts one box descriptor per valid/ready handshake,
// clips it against the visible screen, then emits one pixel per clock in
// row-major order to the vga_adapter plot interface, finishing with a
// one-cycle done pulse.
//
// Handshake: a descriptor transfers on a rising edge where s_valid and
// s_ready are both high. s_ready is high only in IDLE. All in_* fields are
// captured on that edge and ignored at every other time. An upstream that
// keeps s_valid high gets its next transfer only once IDLE is re-entered.
module box_rasterizer #(
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [8:0] in_box_x,
  input  logic [8:0] in_box_y,
  input  logic [8:0] in_box_w,
  input  logic [8:0] in_box_h,
  input  logic [2:0] in_box_color,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic       plot,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;

  // Descriptor captured at the handshake.
  logic [8:0] box_x;
  logic [8:0] box_y;
  logic [8:0] box_w;
  logic [8:0] box_h;
  logic [2:0] box_color;

  // Exclusive clipped end coordinates; 10 bits so x + w cannot wrap at 511.
  logic [9:0] x_end;
  logic [9:0] y_end;

  // Coordinate of the pixel being presented on vga_x/vga_y this cycle.
  logic [8:0] cur_x;
  logic [8:0] cur_y;

  logic [9:0] x_sum;
  logic [9:0] y_sum;
  logic [9:0] x_lim;
  logic [9:0] y_lim;
  logic       empty_box;
  logic       last_col;
  logic       last_row;
  logic [8:0] next_x;
  logic [8:0] next_y;

  // Clipping arithmetic for LOAD and scan-position decode for DRAW.
  always_comb begin
    x_sum     = {1'b0, box_x} + {1'b0, box_w};
    y_sum     = {1'b0, box_y} + {1'b0, box_h};
    x_lim     = (x_sum > {1'b0, SCREEN_WIDTH})  ? {1'b0, SCREEN_WIDTH}  : x_sum;
    y_lim     = (y_sum > {1'b0, SCREEN_HEIGHT}) ? {1'b0, SCREEN_HEIGHT} : y_sum;
    empty_box = (box_w == 9'd0) || (box_h == 9'd0) ||
                (box_x >= SCREEN_WIDTH) || (box_y >= SCREEN_HEIGHT);
    last_col  = ({1'b0, cur_x} == (x_end - 10'd1));
    last_row  = ({1'b0, cur_y} == (y_end - 10'd1));
    next_x    = cur_x + 9'd1;
    next_y    = cur_y + 9'd1;
  end

  assign s_ready   = (state == IDLE);
  assign fsm_state = state;

  // Main FSM: the first pixel is registered on leaving LOAD so that plot is
  // high in exactly the DRAW cycles; each DRAW edge presents the next pixel.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      box_x     <= 9'd0;
      box_y     <= 9'd0;
      box_w     <= 9'd0;
      box_h     <= 9'd0;
      box_color <= 3'd0;
      x_end     <= 10'd0;
      y_end     <= 10'd0;
      cur_x     <= 9'd0;
      cur_y     <= 9'd0;
      vga_x     <= 9'd0;
      vga_y     <= 8'd0;
      plot      <= 1'b0;
      colour    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          if (s_valid) begin
            box_x     <= in_box_x;
            box_y     <= in_box_y;
            box_w     <= in_box_w;
            box_h     <= in_box_h;
            box_color <= in_box_color;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          x_end <= x_lim;
          y_end <= y_lim;
          cur_x <= box_x;
          cur_y <= box_y;
          if (empty_box) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            plot   <= 1'b1;
            vga_x  <= box_x;
            vga_y  <= box_y[7:0];
            colour <= box_color;
            state  <= DRAW;
          end
        end
        DRAW: begin
          if (last_col && last_row) begin
            plot  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (last_col) begin
            cur_x <= box_x;
            cur_y <= next_y;
            vga_x <= box_x;
            vga_y <= next_y[7:0];
          end else begin
            cur_x <= next_x;
            vga_x <= next_x;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          plot  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_rasterizer.sv
// Testbench for box_rasterizer: directed and randomized boxes checked
// against a row-major pixel list built from the clipping rules.
module tb_box_rasterizer;

  localparam int SW = 320;
  localparam int SH = 240;

  logic       clock;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic [8:0] in_box_x;
  logic [8:0] in_box_y;
  logic [8:0] in_box_w;
  logic [8:0] in_box_h;
  logic [2:0] in_box_color;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic       plot;
  logic [2:0] colour;
  logic       busy;
  logic       done;
  logic [1:0] fsm_state;

  int compared;
  int mismatched;

  box_rasterizer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .in_box_x     (in_box_x),
    .in_box_y     (in_box_y),
    .in_box_w     (in_box_w),
    .in_box_h     (in_box_h),
    .in_box_color (in_box_color),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .plot         (plot),
    .colour       (colour),
    .busy         (busy),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a descriptor and complete the handshake; returns in cycle 1.
  task automatic send_box(input int bx, input int by, input int bw, input int bh,
                          input logic [2:0] bc, input bit hold);
    int waited;
    waited       = 0;
    in_box_x     = 9'(bx);
    in_box_y     = 9'(by);
    in_box_w     = 9'(bw);
    in_box_h     = 9'(bh);
    in_box_color = bc;
    s_valid      = 1'b1;
    while (s_ready !== 1'b1 && waited < 2000) begin
      @(posedge clock); #1;
      waited++;
    end
    compared++;
    if (s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, want 1", s_ready, waited);
    end
    @(posedge clock); #1;
    if (!hold) s_valid = 1'b0;
  endtask

  // Scoreboard for one box: called in cycle 1, returns in cycle P+3.
  task automatic check_box(input int bx, input int by, input int bw, input int bh,
                           input logic [2:0] bc);
    logic [16:0] exp_q[$];
    logic [16:0] exp_px;
    logic [16:0] got;
    int xe, ye, p;
    xe = (bx + bw > SW) ? SW : bx + bw;
    ye = (by + bh > SH) ? SH : by + bh;
    for (int yy = by; yy < ye; yy++)
      for (int xx = bx; xx < xe; xx++)
        exp_q.push_back({9'(xx), 8'(yy)});
    p = exp_q.size();

    compared++;
    if (plot !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL load_cycle box(%0d,%0d,%0d,%0d): plot=%b busy=%b done=%b s_ready=%b, want 0 1 0 0",
               bx, by, bw, bh, plot, busy, done, s_ready);
    end

    for (int c = 2; c <= p + 1; c++) begin
      @(posedge clock); #1;
      exp_px = exp_q.pop_front();
      got    = {vga_x, vga_y};
      compared++;
      if (plot !== 1'b1 || got !== exp_px || colour !== bc || busy !== 1'b1 ||
          done !== 1'b0 || s_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL pixel cycle %0d: plot=%b xy=(%0d,%0d) col=%b busy=%b done=%b rdy=%b, want plot=1 xy=(%0d,%0d) col=%b busy=1 done=0 rdy=0",
                 c, plot, vga_x, vga_y, colour, busy, done, s_ready,
                 exp_px[16:8], exp_px[7:0], bc);
      end
    end

    @(posedge clock); #1;
    compared++;
    if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL done_cycle %0d box(%0d,%0d,%0d,%0d): done=%b plot=%b busy=%b s_ready=%b, want 1 0 1 0",
               p + 2, bx, by, bw, bh, done, plot, busy, s_ready);
    end

    @(posedge clock); #1;
    compared++;
    if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL idle_after cycle %0d box(%0d,%0d,%0d,%0d): done=%b plot=%b busy=%b s_ready=%b, want 0 0 0 1",
               p + 3, bx, by, bw, bh, done, plot, busy, s_ready);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    s_valid      = 1'b0;
    in_box_x     = '0;
    in_box_y     = '0;
    in_box_w     = '0;
    in_box_h     = '0;
    in_box_color = '0;
    repeat (3) @(posedge clock);
    #1;
    compared++;
    if (plot !== 1'b0 || vga_x !== 9'd0 || vga_y !== 8'd0 || colour !== 3'd0 ||
        busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_values: plot=%b x=%0d y=%0d col=%b busy=%b done=%b rdy=%b, want all 0 and rdy=1",
               plot, vga_x, vga_y, colour, busy, done, s_ready);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_column();
    send_box(0, 96, 10, 48, 3'b010, 1'b0);
    check_box(0, 96, 10, 48, 3'b010);
  endtask

  task automatic test_clip();
    send_box(315, 236, 10, 10, 3'b111, 1'b0);
    check_box(315, 236, 10, 10, 3'b111);
    // x + w exceeds 511 in 9 bits; must still clip to the right edge
    send_box(300, 230, 300, 300, 3'b101, 1'b0);
    check_box(300, 230, 300, 300, 3'b101);
  endtask

  task automatic test_empty();
    send_box(20, 20, 0, 5, 3'b001, 1'b0);
    check_box(20, 20, 0, 5, 3'b001);
    send_box(320, 10, 4, 4, 3'b011, 1'b0);
    check_box(320, 10, 4, 4, 3'b011);
    send_box(10, 240, 4, 4, 3'b110, 1'b0);
    check_box(10, 240, 4, 4, 3'b110);
    send_box(500, 10, 20, 2, 3'b110, 1'b0);
    check_box(500, 10, 20, 2, 3'b110);
  endtask

  task automatic test_single_pixel();
    send_box(100, 50, 1, 1, 3'b100, 1'b0);
    check_box(100, 50, 1, 1, 3'b100);
  endtask

  task automatic test_back_to_back();
    send_box(40, 30, 1, 2, 3'b001, 1'b1);
    // B presented immediately with s_valid still high; A must be unaffected
    in_box_x     = 9'd200;
    in_box_y     = 9'd100;
    in_box_w     = 9'd2;
    in_box_h     = 9'd1;
    in_box_color = 3'b110;
    check_box(40, 30, 1, 2, 3'b001);
    send_box(200, 100, 2, 1, 3'b110, 1'b0);
    check_box(200, 100, 2, 1, 3'b110);
  endtask

  task automatic test_reset_mid_draw();
    send_box(0, 96, 10, 48, 3'b010, 1'b0);
    repeat (100) begin
      @(posedge clock); #1;
    end
    compared++;
    if (plot !== 1'b1 || vga_x !== 9'd9 || vga_y !== 8'd105) begin
      mismatched++;
      $display("FAIL pixel100: plot=%b xy=(%0d,%0d), want plot=1 xy=(9,105)", plot, vga_x, vga_y);
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    compared++;
    if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_abort: plot=%b done=%b busy=%b s_ready=%b, want 0 0 0 1",
               plot, done, busy, s_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      compared++;
      if (plot !== 1'b0 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL after_abort %0d: plot=%b done=%b, want 0 0", i, plot, done);
      end
    end
    send_box(7, 3, 3, 2, 3'b011, 1'b0);
    check_box(7, 3, 3, 2, 3'b011);
  endtask

  task automatic test_random();
    int bx, by, bw, bh;
    logic [2:0] bc;
    for (int i = 0; i < 16; i++) begin
      bx = $urandom_range(0, 340);
      by = $urandom_range(0, 250);
      bw = $urandom_range(0, 24);
      bh = $urandom_range(0, 10);
      bc = 3'($urandom_range(0, 7));
      send_box(bx, by, bw, bh, bc, 1'b0);
      check_box(bx, by, bw, bh, bc);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_column();
    test_clip();
    test_empty();
    test_single_pixel();
    test_back_to_back();
    test_reset_mid_draw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/box_rasterizer.md
Name: box_rasterizer

Overview:
Downstream stage of screenDrawer. It accepts one box descriptor (x, y, w, h, colour) per valid/ready handshake and clips the box to the screen. It then scans the box row-major and emits one pixel per clock to the vga_adapter plot interface. It signals completion so the screen drawer can sequence the erase and redraw of the paddles and ball.

Parameters:
SCREEN_WIDTH, 9'd320, visible width in pixels; x >= this is off-screen
SCREEN_HEIGHT, 9'd240, visible height in pixels; y >= this is off-screen

Ports:
clock  in  1  system clock (CLOCK_50)
reset_n  in  1  synchronous active-low reset
s_valid  in  1  upstream descriptor valid
s_ready  out  1  block can accept a descriptor
in_box_x  in  9  box left x
in_box_y  in  9  box top y
in_box_w  in  9  box width in pixels
in_box_h  in  9  box height in pixels
in_box_color  in  3  box colour {R,G,B}
vga_x  out  9  pixel x to vga_adapter
vga_y  out  8  pixel y to vga_adapter
plot  out  1  pixel write strobe
colour  out  3  pixel colour
busy  out  1  descriptor accepted and not yet finished
done  out  1  one-cycle pulse when a box is finished

Behaviour:
- Clock and reset: single clock domain, clock; reset_n is synchronous and active-low.
- Reset values:
  - state = IDLE, s_ready = 1
  - plot = 0, vga_x = 0, vga_y = 0, colour = 0
  - busy = 0, done = 0
  - A reset mid-draw aborts immediately: no further plots and no done pulse.
- Output registering: all outputs except s_ready are registered. s_ready = (state == IDLE).
- Handshake:
  - Transfer occurs on a rising edge where s_valid & s_ready.
  - All in_* fields are latched on that edge. Inputs are ignored at all other times.
  - Upstream may hold s_valid high; no second transfer occurs until IDLE is re-entered.
- State machine: IDLE -> LOAD -> (DRAW | DONE) -> DONE -> IDLE.
  - IDLE: s_ready = 1, busy = 0. On transfer, go to LOAD.
  - LOAD (1 cycle):
    - Compute in 10-bit unsigned: x_end = min(x + w, SCREEN_WIDTH), y_end = min(y + h, SCREEN_HEIGHT).
    - Set cur_x = x, cur_y = y.
    - If w == 0, h == 0, x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT, go to DONE (empty box). Otherwise go to DRAW.
  - DRAW:
    - Each cycle register plot = 1, vga_x = cur_x, vga_y = cur_y[7:0], colour = latched colour.
    - If cur_x == x_end - 1: cur_x <= x and cur_y <= cur_y + 1. Otherwise cur_x <= cur_x + 1.
    - When cur_x == x_end - 1 and cur_y == y_end - 1, go to DONE after this pixel.
  - DONE (1 cycle): done = 1, plot = 0, then IDLE.
- Timing, with the handshake edge ending cycle 0 and P = (x_end - x) * (y_end - y):
  - LOAD in cycle 1.
  - plot high in cycles 2 through P+1, with exactly P pixels, each pixel exactly once, row-major.
  - done high in cycle P+2.
  - s_ready high again in cycle P+3.
  - Empty box: done in cycle 2, no plot.
- busy: 1 from LOAD through DONE inclusive.
- plot: 0 in every cycle outside DRAW.
- Clipping:
  - Partially off-screen boxes are truncated at the right and bottom edges. No pixel with vga_x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT is ever emitted.
  - The 10-bit sum prevents x + w wrap-around at 511.
- colour and coordinates hold their last values when plot = 0. vga_adapter ignores them.

Test Plan:
- Box (0,96,10,48,3'b010) -> 480 plots in consecutive cycles 2..481, first (0,96), row wrap (9,96) -> (0,97), last (9,143), all colour 010; done in cycle 482.
- Box (315,236,10,10,3'b111) -> clipped to 5x4 = 20 plots, first (315,236), last (319,239), no x >= 320 or y >= 240; done in cycle 22.
- Box (20,20,0,5) and box (320,10,4,4) -> zero plots, done in cycle 2, s_ready = 1 in cycle 3.
- s_valid held high with box A (1x2) then box B (2x1) -> s_ready low cycles 1..4; B accepted in cycle 5 (the first s_ready-high cycle after A's done); B's inputs changing during A do not alter A's pixels.
- reset_n low for one cycle during pixel 100 of a 10x48 box -> plot = 0, done = 0, busy = 0, s_ready = 1 on the following cycle; a new box is then drawn from its first pixel.
- Single-pixel box (100,50,1,1,3'b100) -> exactly one plot at (100,50) in cycle 2, done in cycle 3.
